// File: rtl/vme_cmd_sequencer.sv
// Single-command VME A24/D16 master: takes one command word, runs one bus cycle
// with a DTACK handshake, and returns read data plus status with a one-cycle pulse.
module vme_cmd_sequencer #(
  parameter int         ADDR_SETUP    = 2,
  parameter int         DTACK_TIMEOUT = 255,
  parameter int         REL_TIMEOUT   = 255,
  parameter logic [5:0] AM_CODE       = 6'h39
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic [31:0] vme_dat_reg_out,
  output logic [23:0] vme_addr,
  output logic [5:0]  vme_am,
  output logic        vme_as_n,
  output logic [1:0]  vme_ds_n,
  output logic        vme_write_n,
  output logic [15:0] vme_data_out,
  output logic        vme_data_oe,
  input  logic [15:0] vme_data_in,
  input  logic        vme_dtack_n,
  input  logic        vme_berr_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_REPORT
  } state_t;

  localparam logic [15:0] L_AS_AT    = 16'(ADDR_SETUP - 1);
  localparam logic [15:0] L_DS_AT    = 16'(ADDR_SETUP);
  localparam logic [15:0] L_DT_LAST  = 16'(DTACK_TIMEOUT - 1);
  localparam logic [15:0] L_REL_LAST = 16'(REL_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic        r_dtack_s1, r_dtack_s2;
  logic        r_berr_s1, r_berr_s2;
  logic        r_is_read;
  logic        r_to, r_berr, r_ill;
  logic [15:0] r_res;

  logic w_valid_cmd;
  logic w_berr_hit;
  logic w_dtack_hit;
  logic w_dt_to;
  logic w_rel_ok;
  logic w_rel_to;
  logic w_unused_bits;

  assign w_valid_cmd   = vme_cmd_reg[25] | vme_cmd_reg[24];
  assign w_berr_hit    = ~r_berr_s2;
  assign w_dtack_hit   = ~r_dtack_s2;
  assign w_dt_to       = (r_cnt == L_DT_LAST);
  assign w_rel_ok      = r_dtack_s2 & r_berr_s2;
  assign w_rel_to      = (r_cnt == L_REL_LAST);
  assign w_unused_bits = &{1'b0, vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

  assign vme_cmd_rd = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = w_valid_cmd ? S_SETUP : S_REPORT;
      S_SETUP:   if (r_cnt == L_DS_AT) w_state_nxt = S_STROBE;
      S_STROBE:  if (w_berr_hit || w_dtack_hit || w_dt_to) w_state_nxt = S_RELEASE;
      S_RELEASE: if (w_rel_ok || w_rel_to) w_state_nxt = S_REPORT;
      S_REPORT:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Counter restarts from zero on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE || w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dtack_s1 <= 1'b1;
      r_dtack_s2 <= 1'b1;
      r_berr_s1  <= 1'b1;
      r_berr_s2  <= 1'b1;
    end else begin
      r_dtack_s1 <= vme_dtack_n;
      r_dtack_s2 <= r_dtack_s1;
      r_berr_s1  <= vme_berr_n;
      r_berr_s2  <= r_berr_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vme_dat_wr      <= 1'b0;
      vme_dat_reg_out <= '0;
      vme_addr        <= '0;
      vme_am          <= '0;
      vme_as_n        <= 1'b1;
      vme_ds_n        <= 2'b11;
      vme_write_n     <= 1'b1;
      vme_data_out    <= '0;
      vme_data_oe     <= 1'b0;
      r_is_read       <= 1'b0;
      r_to            <= 1'b0;
      r_berr          <= 1'b0;
      r_ill           <= 1'b0;
      r_res           <= '0;
    end else begin
      vme_dat_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_to      <= 1'b0;
            r_berr    <= 1'b0;
            r_res     <= '0;
            r_ill     <= ~w_valid_cmd;
            r_is_read <= vme_cmd_reg[25];
            if (w_valid_cmd) begin
              vme_addr    <= vme_cmd_reg[23:0];
              vme_am      <= AM_CODE;
              // read wins when both direction bits are set
              vme_write_n <= vme_cmd_reg[25];
              vme_data_oe <= ~vme_cmd_reg[25];
              if (!vme_cmd_reg[25]) vme_data_out <= vme_dat_reg_in[15:0];
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == L_AS_AT) vme_as_n <= 1'b0;
          if (w_state_nxt == S_STROBE) vme_ds_n <= 2'b00;
        end
        S_STROBE: begin
          if (w_state_nxt == S_RELEASE) begin
            vme_as_n    <= 1'b1;
            vme_ds_n    <= 2'b11;
            vme_data_oe <= 1'b0;
            vme_write_n <= 1'b1;
            if (w_berr_hit) begin
              r_berr <= 1'b1;
            end else if (w_dtack_hit) begin
              if (r_is_read) r_res <= vme_data_in;
            end else begin
              r_to <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          if (!w_rel_ok && w_rel_to) r_to <= 1'b1;
        end
        S_REPORT: begin
          vme_dat_wr      <= 1'b1;
          vme_dat_reg_out <= {13'd0, r_ill, r_berr, r_to, r_res};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_cmd_sequencer.sv
// Directed bench for vme_cmd_sequencer: a table of single-command vectors driven
// through a simple bus-slave task, plus back-to-back and mid-cycle reset sequences.
module tb_vme_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] vme_cmd_reg;
  logic [31:0] vme_dat_reg_in;
  logic        vme_cmd_rd;
  logic        vme_dat_wr;
  logic [31:0] vme_dat_reg_out;
  logic [23:0] vme_addr;
  logic [5:0]  vme_am;
  logic        vme_as_n;
  logic [1:0]  vme_ds_n;
  logic        vme_write_n;
  logic [15:0] vme_data_out;
  logic        vme_data_oe;
  logic [15:0] vme_data_in;
  logic        vme_dtack_n;
  logic        vme_berr_n;

  always #5 clk = ~clk;

  vme_cmd_sequencer #(
    .ADDR_SETUP(2),
    .DTACK_TIMEOUT(16),
    .REL_TIMEOUT(16),
    .AM_CODE(6'h39)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .vme_cmd_reg(vme_cmd_reg),
    .vme_dat_reg_in(vme_dat_reg_in),
    .vme_cmd_rd(vme_cmd_rd),
    .vme_dat_wr(vme_dat_wr),
    .vme_dat_reg_out(vme_dat_reg_out),
    .vme_addr(vme_addr),
    .vme_am(vme_am),
    .vme_as_n(vme_as_n),
    .vme_ds_n(vme_ds_n),
    .vme_write_n(vme_write_n),
    .vme_data_out(vme_data_out),
    .vme_data_oe(vme_data_oe),
    .vme_data_in(vme_data_in),
    .vme_dtack_n(vme_dtack_n),
    .vme_berr_n(vme_berr_n)
  );

  int total = 0;
  int bad   = 0;

  // mode: 0 DTACK, 1 DTACK+BERR same cycle, 2 no response, 3 BERR only
  typedef struct {
    logic [31:0] cmd;
    logic [31:0] din;
    int          k;
    int          mode;
    logic [15:0] rdata;
    logic [31:0] exp_out;
    bit          exp_bus;
    bit          exp_wn;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input string tag, input logic [31:0] cmd, input logic [31:0] din,
                         input int k, input int mode, input logic [15:0] rdata,
                         input logic [31:0] exp_out, input bit exp_bus, input bit exp_wn,
                         input bit keep_start, input bit already);
    int          ds_cnt = 0;
    int          n = 1;
    int          pulse_n = 0;
    bit          saw_as = 0, saw_ds = 0, got = 0, responded = 0;
    logic [23:0] a_addr = '0;
    logic [5:0]  a_am = '0;
    logic        a_wn = 1'b1, a_oe = 1'b0;
    logic [15:0] a_dout = '0;
    logic [31:0] a_res = '0;
    if (!already) begin
      @(negedge clk);
      vme_cmd_reg    = cmd;
      vme_dat_reg_in = din;
      start          = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    chk({tag, "_cmdrd_busy"}, 32'(vme_cmd_rd), 32'd0);
    while (!got && n <= 200) begin
      if (!vme_as_n) saw_as = 1;
      if (vme_ds_n == 2'b00) begin
        if (!saw_ds) begin
          a_addr = vme_addr; a_am = vme_am; a_wn = vme_write_n;
          a_oe = vme_data_oe; a_dout = vme_data_out;
        end
        saw_ds = 1;
        ds_cnt++;
        if (ds_cnt == k + 1 && !responded) begin
          responded = 1;
          case (mode)
            0: begin vme_dtack_n = 1'b0; vme_data_in = rdata; end
            1: begin vme_dtack_n = 1'b0; vme_berr_n = 1'b0; vme_data_in = rdata; end
            3: vme_berr_n = 1'b0;
            default: ;
          endcase
        end
      end else if (vme_ds_n == 2'b11) begin
        vme_dtack_n = 1'b1;
        vme_berr_n  = 1'b1;
      end
      if (vme_dat_wr) begin
        got = 1;
        pulse_n = n;
        a_res = vme_dat_reg_out;
        chk({tag, "_cmdrd_at_pulse"}, 32'(vme_cmd_rd), 32'd1);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_pulse_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_result"}, a_res, exp_out);
      if (exp_bus) begin
        chk({tag, "_as_ds_seen"}, 32'({saw_as, saw_ds}), 32'd3);
        chk({tag, "_addr"}, 32'(a_addr), 32'(cmd[23:0]));
        chk({tag, "_am"}, 32'(a_am), 32'h39);
        chk({tag, "_write_n"}, 32'(a_wn), 32'(exp_wn));
        chk({tag, "_oe"}, 32'(a_oe), 32'(!exp_wn));
        if (!exp_wn) chk({tag, "_data_out"}, 32'(a_dout), 32'(din[15:0]));
        if (mode == 2) chk({tag, "_ds_clocks"}, 32'(ds_cnt), 32'd16);
      end else begin
        chk({tag, "_no_bus"}, 32'({saw_as, saw_ds}), 32'd0);
        chk({tag, "_latency"}, 32'(pulse_n), 32'd2);
      end
    end
    if (!keep_start) begin
      @(negedge clk);
      chk({tag, "_single_pulse"}, 32'(vme_dat_wr), 32'd0);
      chk({tag, "_cmdrd_idle"}, 32'(vme_cmd_rd), 32'd1);
    end
  endtask

  initial begin
    bit seen;
    vecs[0] = '{32'h02A84100, 32'h0, 3, 0, 16'hBEEF, 32'h0000BEEF, 1, 1};
    vecs[1] = '{32'h01A87000, 32'h0000A5A5, 0, 0, 16'h0, 32'h00000000, 1, 0};
    vecs[2] = '{32'h02123456, 32'h0, 0, 2, 16'h0, 32'h00010000, 1, 1};
    vecs[3] = '{32'h02000010, 32'h0, 1, 1, 16'h5555, 32'h00020000, 1, 1};
    vecs[4] = '{32'h00A80010, 32'h0, 0, 0, 16'h0, 32'h00040000, 0, 1};
    vecs[5] = '{32'h03ABCDEF, 32'h0000FFFF, 0, 0, 16'h1234, 32'h00001234, 1, 1};
    vecs[6] = '{32'h01000002, 32'hFFFF1111, 0, 2, 16'h0, 32'h00010000, 1, 0};
    vecs[7] = '{32'h02FFFFFE, 32'h0, 5, 0, 16'h8001, 32'h00008001, 1, 1};
    vecs[8] = '{32'h01000100, 32'h00003C3C, 2, 3, 16'h0, 32'h00020000, 1, 0};
    vecs[9] = '{32'hFC001234, 32'h0, 0, 0, 16'h0, 32'h00040000, 0, 1};

    rst_n = 1'b0; start = 1'b0; vme_cmd_reg = '0; vme_dat_reg_in = '0;
    vme_data_in = '0; vme_dtack_n = 1'b1; vme_berr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_rd", 32'(vme_cmd_rd), 32'd1);
    chk("rst_dat_wr", 32'(vme_dat_wr), 32'd0);
    chk("rst_dat_out", vme_dat_reg_out, 32'd0);
    chk("rst_strobes", 32'({vme_as_n, vme_ds_n, vme_write_n, vme_data_oe}), 32'b11110);
    chk("rst_addr_am", 32'({vme_am, vme_addr}), 32'd0);
    chk("rst_data_out", 32'(vme_data_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].cmd, vecs[i].din, vecs[i].k, vecs[i].mode,
              vecs[i].rdata, vecs[i].exp_out, vecs[i].exp_bus, vecs[i].exp_wn, 0, 0);
    end

    // start held high through the pulse launches the next command at once
    run_txn("b2b1", 32'h02001000, 32'h0, 1, 0, 16'h1111, 32'h00001111, 1, 1, 1, 0);
    run_txn("b2b2", 32'h02001000, 32'h0, 0, 0, 16'h2222, 32'h00002222, 1, 1, 0, 1);

    // reset while the data strobes are low
    @(negedge clk);
    vme_cmd_reg = 32'h02A84100;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 20 && vme_ds_n != 2'b00; j++) @(negedge clk);
    chk("mid_ds_reached", 32'(vme_ds_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_as", 32'(vme_as_n), 32'd1);
    chk("mid_rst_ds", 32'(vme_ds_n), 32'd3);
    chk("mid_rst_cmd_rd", 32'(vme_cmd_rd), 32'd1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (vme_dat_wr) seen = 1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (vme_dat_wr) seen = 1;
    end
    chk("mid_rst_no_pulse", 32'(seen), 32'd0);
    run_txn("post_rst", 32'h02A84100, 32'h0, 3, 0, 16'hBEEF, 32'h0000BEEF, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
